// File: rtl/multi_edge_detector.sv
`default_nettype none
// ============================================================================
// Module   : multi_edge_detector
// Brief    : N-channel edge detector with per-channel rise/fall/both/off mode,
//            optional synchroniser, sticky flags and saturating event counters.
//            Define EDGE_DEBOUNCE_EN to add a per-channel stability filter.
// Revision : 1.0  initial release
// ============================================================================
module multi_edge_detector #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int DEB_CYCLES  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       sig_in,
  input  logic [2*N_CH-1:0]     mode,
  input  logic [N_CH-1:0]       clr,
  output logic [N_CH-1:0]       edge_pulse,
  output logic                  edge_any,
  output logic [N_CH-1:0]       edge_sticky,
  output logic [N_CH*CNT_W-1:0] edge_count
);

`ifdef EDGE_DEBOUNCE_EN
  // The filtered level starts at 0, so priming must also cover the debounce window.
  localparam int c_PRIME_LEN = SYNC_STAGES + DEB_CYCLES + 1;
`else
  localparam int c_PRIME_LEN = SYNC_STAGES + 1;
`endif
  localparam int                 c_PRIME_W    = $clog2(c_PRIME_LEN + 1);
  localparam logic [c_PRIME_W-1:0] c_PRIME_INIT = c_PRIME_W'(c_PRIME_LEN);
  localparam logic [c_PRIME_W-1:0] c_PRIME_ONE  = c_PRIME_W'(1);
  localparam logic [CNT_W-1:0]   c_CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]   c_CNT_MAX    = {CNT_W{1'b1}};

  logic [N_CH-1:0]      w_sync;
  logic [N_CH-1:0]      w_s;
  logic [N_CH-1:0]      w_rise;
  logic [N_CH-1:0]      w_fall;
  logic [N_CH-1:0]      w_evt;
  logic [N_CH-1:0]      r_prev;
  logic [N_CH-1:0]      r_pulse;
  logic [N_CH-1:0]      r_sticky;
  logic                 r_any;
  logic [CNT_W-1:0]     r_cnt [N_CH];
  logic [c_PRIME_W-1:0] r_prime;

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [N_CH-1:0] r_chain [SYNC_STAGES];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < SYNC_STAGES; k++) r_chain[k] <= '0;
        end else begin
          r_chain[0] <= sig_in;
          for (int k = 1; k < SYNC_STAGES; k++) r_chain[k] <= r_chain[k-1];
        end
      end
      assign w_sync = r_chain[SYNC_STAGES-1];
    end else begin : g_nosync
      assign w_sync = sig_in;
    end
  endgenerate

`ifdef EDGE_DEBOUNCE_EN
  localparam int                 c_DEB_W    = $clog2(DEB_CYCLES + 1);
  localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEB_CYCLES - 1);
  localparam logic [c_DEB_W-1:0] c_DEB_ONE  = c_DEB_W'(1);

  logic [N_CH-1:0]    r_s;
  logic [c_DEB_W-1:0] r_stab [N_CH];

  // Filtered level flips only after DEB_CYCLES consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s <= '0;
      for (int i = 0; i < N_CH; i++) r_stab[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (w_sync[i] == r_s[i]) begin
          r_stab[i] <= '0;
        end else if (r_stab[i] == c_DEB_LAST) begin
          r_s[i]    <= w_sync[i];
          r_stab[i] <= '0;
        end else begin
          r_stab[i] <= r_stab[i] + c_DEB_ONE;
        end
      end
    end
  end
  assign w_s = r_s;
`else
  assign w_s = w_sync;
`endif

  always_comb begin
    w_rise = w_s & ~r_prev;
    w_fall = ~w_s & r_prev;
    w_evt  = '0;
    if (r_prime == '0) begin
      for (int i = 0; i < N_CH; i++) begin
        w_evt[i] = (mode[2*i] & w_rise[i]) | (mode[2*i+1] & w_fall[i]);
      end
    end
  end

  // History follows the filtered level unconditionally so a mode change never sees a stale edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev   <= '0;
      r_pulse  <= '0;
      r_any    <= 1'b0;
      r_sticky <= '0;
      r_prime  <= c_PRIME_INIT;
      for (int i = 0; i < N_CH; i++) r_cnt[i] <= '0;
    end else begin
      r_prev  <= w_s;
      r_pulse <= w_evt;
      r_any   <= |w_evt;
      if (r_prime != '0) r_prime <= r_prime - c_PRIME_ONE;
      for (int i = 0; i < N_CH; i++) begin
        if (w_evt[i]) begin
          r_sticky[i] <= 1'b1;
          if (clr[i])                    r_cnt[i] <= c_CNT_ONE;
          else if (r_cnt[i] != c_CNT_MAX) r_cnt[i] <= r_cnt[i] + c_CNT_ONE;
        end else if (clr[i]) begin
          r_sticky[i] <= 1'b0;
          r_cnt[i]    <= '0;
        end
      end
    end
  end

  assign edge_pulse  = r_pulse;
  assign edge_any    = r_any;
  assign edge_sticky = r_sticky;

  generate
    for (genvar g = 0; g < N_CH; g++) begin : g_cnt_out
      assign edge_count[g*CNT_W +: CNT_W] = r_cnt[g];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multi_edge_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_edge_detector
// Brief    : Scoreboard bench for multi_edge_detector (N_CH=4, SYNC_STAGES=2, CNT_W=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_multi_edge_detector;
  localparam int N_CH        = 4;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 4;
  localparam int DEB_CYCLES  = 4;
`ifdef EDGE_DEBOUNCE_EN
  localparam int LAT = SYNC_STAGES + 1 + DEB_CYCLES;
`else
  localparam int LAT = SYNC_STAGES + 1;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_CH-1:0]       sig_in;
  logic [2*N_CH-1:0]     mode;
  logic [N_CH-1:0]       clr;
  logic [N_CH-1:0]       edge_pulse;
  logic                  edge_any;
  logic [N_CH-1:0]       edge_sticky;
  logic [N_CH*CNT_W-1:0] edge_count;

  multi_edge_detector #(
    .N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W), .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .mode(mode), .clr(clr),
    .edge_pulse(edge_pulse), .edge_any(edge_any),
    .edge_sticky(edge_sticky), .edge_count(edge_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [3:0]  pulse;
    logic [3:0]  sticky;
    logic [15:0] cnt;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         cyc    = 0;
  int         errors = 0;
  int         checks = 0;
  logic [3:0] m_sticky;
  int         m_cnt [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  function automatic logic [15:0] pack_cnt();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) v[i*4 +: 4] = 4'(m_cnt[i]);
    return v;
  endfunction

  // Called right after sig_in changes: the qualifying event shows LAT edges later.
  task automatic expect_event(input int ch, input bit clr_hit);
    exp_t e;
    m_sticky[ch] = 1'b1;
    if (clr_hit)             m_cnt[ch] = 1;
    else if (m_cnt[ch] < 15) m_cnt[ch]++;
    e.cyc    = cyc + LAT;
    e.pulse  = 4'(1 << ch);
    e.sticky = m_sticky;
    e.cnt    = pack_cnt();
    q.push_back(e);
  endtask

  task automatic model_reset();
    m_sticky = '0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (edge_pulse !== 4'b0) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got %b expected none (cycle %0d)", edge_pulse, cyc);
        end else begin
          mon_e = q.pop_front();
          check("pulse_cycle", cyc, mon_e.cyc);
          check("pulse_vec", {28'b0, edge_pulse}, {28'b0, mon_e.pulse});
          check("pulse_any", {31'b0, edge_any}, 32'd1);
          check("pulse_sticky", {28'b0, edge_sticky}, {28'b0, mon_e.sticky});
          check("pulse_count", {16'b0, edge_count}, {16'b0, mon_e.cnt});
        end
      end else if (q.size() > 0 && cyc > q[0].cyc) begin
        mon_e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_pulse: got none expected %b at cycle %0d", mon_e.pulse, mon_e.cyc);
      end else begin
        check("idle_any", {31'b0, edge_any}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; sig_in = 4'hF; mode = 8'h55; clr = 4'h0;
    model_reset();
    ticks(3);
    check("reset_pulse", {28'b0, edge_pulse}, 32'd0);
    check("reset_sticky", {28'b0, edge_sticky}, 32'd0);
    check("reset_count", {16'b0, edge_count}, 32'd0);
    rst = 1'b0;
    ticks(12);
    check("prime_sticky", {28'b0, edge_sticky}, 32'd0);
    check("prime_count", {16'b0, edge_count}, 32'd0);
    sig_in = 4'h0;
    ticks(12);
    mode = 8'h2D;

`ifdef EDGE_DEBOUNCE_EN
    sig_in[0] = 1'b1; ticks(3); sig_in[0] = 1'b0;
    ticks(12);
    check("deb_glitch_count", {28'b0, edge_count[3:0]}, 32'd0);
    sig_in[0] = 1'b1; expect_event(0, 1'b0);
    ticks(4); sig_in[0] = 1'b0;
    ticks(14);
    check("deb_stable_count", {28'b0, edge_count[3:0]}, 32'd1);
`else
    // ch0 rise, then held high: one pulse only
    sig_in[0] = 1'b1; expect_event(0, 1'b0);
    ticks(12);
    check("ch0_sticky", {28'b0, edge_sticky}, 32'h1);
    check("ch0_count", {28'b0, edge_count[3:0]}, 32'd1);
    sig_in[0] = 1'b0;
    ticks(6);

    // ch1 both-edge, 20 toggles, saturates at 15
    for (int k = 0; k < 20; k++) begin
      sig_in[1] = ~sig_in[1]; expect_event(1, 1'b0);
      ticks(5);
    end
    ticks(5);
    check("ch1_sat_count", {28'b0, edge_count[7:4]}, 32'd15);
    check("ch1_sticky", {31'b0, edge_sticky[1]}, 32'd1);

    // ch2 fall-only; clr colliding with an event
    sig_in[2] = 1'b1; ticks(6);
    sig_in[2] = 1'b0; expect_event(2, 1'b0); ticks(6);
    sig_in[2] = 1'b1; ticks(6);
    sig_in[2] = 1'b0; expect_event(2, 1'b1);
    ticks(2); clr[2] = 1'b1; tick(); clr[2] = 1'b0;
    ticks(4);
    check("ch2_collide_sticky", {31'b0, edge_sticky[2]}, 32'd1);
    check("ch2_collide_count", {28'b0, edge_count[11:8]}, 32'd1);
    clr[2] = 1'b1; tick(); clr[2] = 1'b0;
    m_sticky[2] = 1'b0; m_cnt[2] = 0;
    check("ch2_clr_sticky", {31'b0, edge_sticky[2]}, 32'd0);
    check("ch2_clr_count", {28'b0, edge_count[11:8]}, 32'd0);
    check("ch1_after_clr2", {28'b0, edge_count[7:4]}, 32'd15);

    // ch3 off while toggling, then enabled with line already high
    sig_in[3] = 1'b1; ticks(5); sig_in[3] = 1'b0; ticks(5); sig_in[3] = 1'b1; ticks(5);
    mode = 8'h6D;
    ticks(8);
    check("ch3_off_count", {28'b0, edge_count[15:12]}, 32'd0);
    sig_in[3] = 1'b0; ticks(6);
    sig_in[3] = 1'b1; expect_event(3, 1'b0);
    ticks(6);

    // reset mid-operation with ch3 held high
    rst = 1'b1; tick();
    model_reset();
    check("midrst_sticky", {28'b0, edge_sticky}, 32'd0);
    check("midrst_count", {16'b0, edge_count}, 32'd0);
    rst = 1'b0;
    ticks(10);
    check("midrst_prime_count", {16'b0, edge_count}, 32'd0);

    // ch1 both-edge, toggle every cycle
    for (int k = 0; k < 6; k++) begin
      sig_in[1] = ~sig_in[1]; expect_event(1, 1'b0);
      tick();
    end
    ticks(6);
    check("ch1_fast_count", {28'b0, edge_count[7:4]}, 32'd6);
`endif

    check("queue_empty", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
